// File: rtl/fpu_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_addsub_arbiter (with fpuAddSub16 datapath)
//  Purpose  : Round-robin sharing of one FP16 add/sub unit between NUM_REQ
//             requesters. Operands are registered at grant, the combinational
//             fpuAddSub16 evaluates them in EXEC, and results are registered
//             and presented on a single tagged valid/ready response channel.
//  Ports    : clock/reset           - clock, synchronous active-high reset
//             req_valid/ready/sub   - per-requester request handshake and op
//             req_in1/req_in2       - packed fp16 operands, 16 bits/requester
//             resp_valid/ready      - shared response handshake
//             resp_id/result/cond/flags - tagged result, {Z,C,N,V}, status
//             busy                  - state != IDLE
//             ops_done              - wrapping count of response handshakes
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// fpuAddSub16: combinational IEEE binary16 add/subtract, round-to-nearest-even.
// o_cond  = {Z, C, N, V}: zero, unordered (NaN result), negative, overflow.
// o_flags = {NV, OF, UF, NX}: invalid, overflow, underflow, inexact.
// ----------------------------------------------------------------------------
module fpuAddSub16 (
    input  logic [15:0] i_in1,
    input  logic [15:0] i_in2,
    input  logic        i_sub,
    output logic [15:0] o_out,
    output logic [3:0]  o_cond,
    output logic [3:0]  o_flags
);
    logic [15:0] w_bx, w_a, w_b, w_packed;
    logic [4:0]  w_ea, w_eb, w_d;
    logic [13:0] w_siga, w_sigb;
    logic [14:0] w_sum;
    logic [5:0]  w_exp;
    logic        w_sticky, w_eff_sub, w_rnd, w_nx, w_ovf, w_nv, w_uf, w_sign, w_is_nan;
    logic        w_nan1, w_nan2, w_snan, w_inf1, w_inf2;

    always_comb begin
        w_bx   = {i_in2[15] ^ i_sub, i_in2[14:0]};
        w_nan1 = (&i_in1[14:10]) && (|i_in1[9:0]);
        w_nan2 = (&i_in2[14:10]) && (|i_in2[9:0]);
        w_snan = (w_nan1 && !i_in1[9]) || (w_nan2 && !i_in2[9]);
        w_inf1 = (&i_in1[14:10]) && (i_in1[9:0] == 10'd0);
        w_inf2 = (&i_in2[14:10]) && (i_in2[9:0] == 10'd0);
        // Larger magnitude goes to A so the subtraction never goes negative.
        if (w_bx[14:0] > i_in1[14:0]) begin
            w_a = w_bx;
            w_b = i_in1;
        end else begin
            w_a = i_in1;
            w_b = w_bx;
        end
        w_eff_sub = w_a[15] ^ w_b[15];
        // Subnormals share the exponent of the smallest normal.
        w_ea   = (w_a[14:10] == 5'd0) ? 5'd1 : w_a[14:10];
        w_eb   = (w_b[14:10] == 5'd0) ? 5'd1 : w_b[14:10];
        w_siga = {|w_a[14:10], w_a[9:0], 3'b000};
        w_sigb = {|w_b[14:10], w_b[9:0], 3'b000};
        w_d    = w_ea - w_eb;
        // Align B; bits shifted out are folded into the sticky bit.
        w_sticky = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (5'(i) < w_d) begin
                w_sticky = w_sticky | w_sigb[0];
                w_sigb   = w_sigb >> 1;
            end
        end
        w_sigb[0] = w_sigb[0] | w_sticky;
        w_sum = w_eff_sub ? ({1'b0, w_siga} - {1'b0, w_sigb})
                          : ({1'b0, w_siga} + {1'b0, w_sigb});
        w_exp = {1'b0, w_ea};
        if (w_sum[14]) begin
            w_sum = {1'b0, w_sum[14:2], w_sum[1] | w_sum[0]};
            w_exp = w_exp + 6'd1;
        end else begin
            // Normalize left, stopping at the subnormal exponent.
            for (int i = 0; i < 13; i++) begin
                if (!w_sum[13] && (w_exp > 6'd1)) begin
                    w_sum = w_sum << 1;
                    w_exp = w_exp - 6'd1;
                end
            end
        end
        w_rnd = w_sum[2] & (w_sum[1] | w_sum[0] | w_sum[3]);
        w_nx  = |w_sum[2:0];
        // Rounding carry out of the mantissa propagates into the exponent field.
        w_packed = {(w_sum[13] ? w_exp : 6'd0), w_sum[12:3]} + 16'(w_rnd);
        // Exact cancellation yields +0 unless both addends were -0.
        w_sign = (w_sum == 15'd0) ? (w_eff_sub ? 1'b0 : w_a[15]) : w_a[15];
        w_ovf  = (w_packed[15:10] >= 6'd31);
        w_nv   = 1'b0;
        o_out  = {w_sign, w_packed[14:0]};
        if (w_ovf) begin
            o_out = {w_sign, 15'h7C00};
            w_nx  = 1'b1;
        end
        w_uf = w_nx && (o_out[14:10] == 5'd0);
        if (w_nan1 || w_nan2) begin
            o_out = 16'h7E00;
            w_nv  = w_snan;
            w_nx  = 1'b0;
            w_ovf = 1'b0;
            w_uf  = 1'b0;
        end else if (w_inf1 || w_inf2) begin
            // A holds the infinity because it has the larger magnitude.
            o_out = (w_inf1 && w_inf2 && w_eff_sub) ? 16'h7E00 : {w_a[15], 15'h7C00};
            w_nv  = w_inf1 && w_inf2 && w_eff_sub;
            w_nx  = 1'b0;
            w_ovf = 1'b0;
            w_uf  = 1'b0;
        end
        w_is_nan = (&o_out[14:10]) && (|o_out[9:0]);
        o_cond   = {(o_out[14:0] == 15'd0), w_is_nan, o_out[15] & !w_is_nan, w_ovf};
        o_flags  = {w_nv, w_ovf, w_uf, w_nx};
    end
endmodule

module fpu_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int CNTW    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_sub,
    input  logic [NUM_REQ*16-1:0] req_in1,
    input  logic [NUM_REQ*16-1:0] req_in2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [15:0]           resp_result,
    output logic [3:0]            resp_cond,
    output logic [3:0]            resp_flags,
    output logic                  busy,
    output logic [CNTW-1:0]       ops_done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state, w_next;
    logic [IDW-1:0]  r_last_grant, r_id, w_winner, w_cand;
    logic            r_sub, w_found, w_grant, w_resp_hs;
    logic [15:0]     r_in1, r_in2, r_result, w_fpu_out;
    logic [3:0]      r_cond, r_flags, w_fpu_cond, w_fpu_flags;
    logic [CNTW-1:0] r_ops_done;
    int              w_pos;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_pos    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(r_last_grant) + 1 + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            w_cand = IDW'(w_pos);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Next state and request accept. req_ready depends only on state and
    // req_valid, never on resp_ready; reset masks it so nothing is accepted.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !reset) begin
                    req_ready[w_winner] = 1'b1;
                    w_next              = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_grant   = (r_state == S_IDLE) && w_found;
    assign w_resp_hs = (r_state == S_RESP) && resp_ready;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_id         <= '0;
            r_sub        <= 1'b0;
            r_in1        <= 16'd0;
            r_in2        <= 16'd0;
            r_result     <= 16'd0;
            r_cond       <= 4'd0;
            r_flags      <= 4'd0;
            r_ops_done   <= '0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_winner;
                r_id         <= w_winner;
                r_sub        <= req_sub[w_winner];
                r_in1        <= req_in1[{w_winner, 4'b0000} +: 16];
                r_in2        <= req_in2[{w_winner, 4'b0000} +: 16];
            end
            if (r_state == S_EXEC) begin
                r_result <= w_fpu_out;
                r_cond   <= w_fpu_cond;
                r_flags  <= w_fpu_flags;
            end
            if (w_resp_hs) r_ops_done <= r_ops_done + CNTW'(1);
        end
    end

    fpuAddSub16 u_addsub (
        .i_in1   (r_in1),
        .i_in2   (r_in2),
        .i_sub   (r_sub),
        .o_out   (w_fpu_out),
        .o_cond  (w_fpu_cond),
        .o_flags (w_fpu_flags)
    );

    assign resp_valid  = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign resp_id     = r_id;
    assign resp_result = r_result;
    assign resp_cond   = r_cond;
    assign resp_flags  = r_flags;
    assign ops_done    = r_ops_done;
endmodule
`default_nettype wire
